mbist_sti_exec: RTL



---
 rtl/mbist_sti_exec_pkg.sv | 27 ++
 rtl/mbist_sti_exec_op_slot_sel.sv | 24 ++
 rtl/mbist_sti_exec.sv | 108 ++++++++++
 3 files changed

// File: rtl/mbist_sti_exec_pkg.sv
// mbist_def: shared stimulus-word layout, slot helpers and executor state encoding.
package mbist_def;
  localparam int BIST_STI_WD = 13;
  localparam int SLOT_WD = 3;
  localparam int SLOT_N = 4;
  localparam int SLOT_IW = 2;
  localparam int DIR_BIT = 12;
  localparam int SLOT0_MSB = 11;
  localparam int VLD_OFF = 2;
  localparam int WR_OFF = 1;
  localparam int POL_OFF = 0;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, NEXT, DONE} state_t;
  function automatic logic [SLOT_WD-1:0] slot_field(input logic [BIST_STI_WD-1:0] sti,
                                                    input logic [SLOT_IW-1:0] idx);
    return sti[SLOT0_MSB - SLOT_WD*int'(idx) -: SLOT_WD];
  endfunction
  function automatic logic [SLOT_N-1:0] valid_vec(input logic [BIST_STI_WD-1:0] sti);
    logic [SLOT_N-1:0] v;
    logic [SLOT_WD-1:0] f;
    v = '0;
    for (int i = 0; i < SLOT_N; i++) begin
      f = slot_field(sti, SLOT_IW'(i));
      v[i] = f[VLD_OFF];
    end
    return v;
  endfunction
endpackage

// File: rtl/mbist_sti_exec_op_slot_sel.sv
// mbist_op_slot_sel: picks the next valid op slot after cur, flagging wrap to the first valid slot.
module mbist_op_slot_sel
  import mbist_def::*;
(
  input  logic [SLOT_N-1:0]  vld,
  input  logic [SLOT_IW-1:0] cur,
  output logic [SLOT_IW-1:0] nxt,
  output logic               wrap,
  output logic [SLOT_IW-1:0] first,
  output logic               any_vld
);
  always_comb begin
    first = '0;
    for (int i = SLOT_N-1; i >= 0; i--) if (vld[i]) first = SLOT_IW'(i);
    nxt = first;
    wrap = 1'b1;
    for (int i = SLOT_N-1; i >= 0; i--)
      if (vld[i] && i > int'(cur)) begin
        nxt = SLOT_IW'(i);
        wrap = 1'b0;
      end
  end
  assign any_vld = |vld;
endmodule

// File: rtl/mbist_sti_exec.sv
// mbist_sti_exec: executes each selector stimulus as a March element over the address range.
module mbist_sti_exec
  import mbist_def::*;
#(
  parameter int BIST_ADDR_WD = 9,
  parameter int BIST_DATA_WD = 32,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END = 9'h1F8,
  parameter logic [BIST_DATA_WD-1:0] BIST_DATA_PAT = 32'h5555_5555
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    hold,
  input  logic [BIST_STI_WD-1:0]  stimulus,
  input  logic                    last_stimulus,
  output logic                    sti_next,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic [BIST_ADDR_WD-1:0] mem_addr,
  output logic [BIST_DATA_WD-1:0] mem_wdata,
  output logic                    cmp_en,
  output logic [BIST_DATA_WD-1:0] exp_data,
  output logic                    busy,
  output logic                    done
);
  localparam logic [BIST_ADDR_WD-1:0] ONE = 1;
  state_t state, state_nx;
  logic [BIST_STI_WD-1:0] sti_q, sti_nx;
  logic [BIST_ADDR_WD-1:0] addr_q, addr_nx, addr_fin;
  logic [SLOT_IW-1:0] slot_q, slot_nx, slot_nxt, slot_first;
  logic [SLOT_N-1:0] vld;
  logic [SLOT_WD-1:0] fld;
  logic [BIST_DATA_WD-1:0] acc_data, rd_data;
  logic wrap, any_vld, dir, acc;
  // LOAD looks at the live stimulus so the first slot is known before it is latched
  assign vld = valid_vec(state == LOAD ? stimulus : sti_q);
  assign dir = sti_q[DIR_BIT];
  assign addr_fin = dir ? BIST_ADDR_START : BIST_ADDR_END;
  assign fld = slot_field(sti_q, slot_q);
  assign acc_data = fld[POL_OFF] ? ~BIST_DATA_PAT : BIST_DATA_PAT;
  assign sti_next = state == NEXT;
  assign busy = state inside {LOAD, RUN, NEXT};
  assign done = state == DONE;
  mbist_op_slot_sel u_sel (
    .vld(vld),
    .cur(slot_q),
    .nxt(slot_nxt),
    .wrap(wrap),
    .first(slot_first),
    .any_vld(any_vld)
  );
  always_comb begin
    state_nx = state;
    sti_nx = sti_q;
    addr_nx = addr_q;
    slot_nx = slot_q;
    acc = 1'b0;
    case (state)
      IDLE, DONE: state_nx = start ? LOAD : state;
      LOAD: begin
        sti_nx = stimulus;
        addr_nx = stimulus[DIR_BIT] ? BIST_ADDR_END : BIST_ADDR_START;
        slot_nx = slot_first;
        state_nx = any_vld ? RUN : NEXT;
      end
      RUN: if (!hold) begin
        acc = 1'b1;
        slot_nx = slot_nxt;
        if (wrap) begin
          if (addr_q == addr_fin) state_nx = NEXT;
          else addr_nx = dir ? addr_q - ONE : addr_q + ONE;
        end
      end
      NEXT: state_nx = last_stimulus ? DONE : LOAD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sti_q <= '0;
      addr_q <= '0;
      slot_q <= '0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rd_data <= '0;
      cmp_en <= 1'b0;
      exp_data <= '0;
    end else begin
      state <= state_nx;
      sti_q <= sti_nx;
      addr_q <= addr_nx;
      slot_q <= slot_nx;
      mem_cs <= acc;
      cmp_en <= mem_cs & ~mem_we;
      if (acc) begin
        mem_we <= fld[WR_OFF];
        mem_addr <= addr_q;
        rd_data <= acc_data;
        if (fld[WR_OFF]) mem_wdata <= acc_data;
      end
      if (mem_cs & ~mem_we) exp_data <= rd_data;
    end
  end
endmodule
